// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type, default geometry and window type for the convolution controller
package conv_pkg;

    localparam int DEF_IMG_WIDTH   = 28;
    localparam int DEF_IMG_HEIGHT  = 28;
    localparam int DEF_KERNEL_DIM  = 3;
    localparam int DEF_KERNEL_SIZE = DEF_KERNEL_DIM * DEF_KERNEL_DIM;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_KDATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        DONE
    } conv_ctrl_state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] conv_win_t [DEF_KERNEL_SIZE];

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: KERNEL_DIM-1 row buffers, combinational read at col, cascading write on each accepted pixel
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int CW   = $clog2(IMG_WIDTH),
    localparam int RD_W = (KERNEL_DIM - 1) * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [CW-1:0]         col,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [RD_W-1:0]       rd_data
);

    logic [DATA_WIDTH-1:0] mem [KERNEL_DIM-1][IMG_WIDTH];

    // row 0 holds the previous image row; each older row inherits the one above it at the same column
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][col] <= din;
            for (int i = 1; i < KERNEL_DIM - 1; i++) mem[i][col] <= mem[i-1][col];
        end
    end

    for (genvar r = 0; r < KERNEL_DIM - 1; r++) begin : g_rd
        assign rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[r][col];
    end

endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: kernel load, line-buffered sliding window and 2-stage valid tracking for the conv datapath (optional CONV_CTRL_STALL_CNT_EN adds stall_cnt)
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int KERNEL_DIM  = DEF_KERNEL_DIM,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KDATA_WIDTH = DEF_KDATA_WIDTH,
    localparam int KERNEL_SIZE = KERNEL_DIM * KERNEL_DIM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
`ifdef CONV_CTRL_STALL_CNT_EN
    output logic [31:0]                       stall_cnt,
`endif
    input  logic                              k_valid,
    output logic                              k_ready,
    input  logic [KDATA_WIDTH-1:0]            k_data,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    input  logic [DATA_WIDTH-1:0]             pix_data,
    output logic                              conv_en,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_image,
    output logic [KERNEL_SIZE*KDATA_WIDTH-1:0] conv_kernel,
    input  logic [DATA_WIDTH-1:0]             conv_feature,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int KW = $clog2(KERNEL_SIZE);

    conv_ctrl_state_t state;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [KW-1:0] k_idx;
    logic [1:0]    vld;
    logic [1:0]    lst;
    logic          stall;
    logic          in_fire;
    logic          out_fire;
    logic          k_fire;
    logic          last_pix;
    logic          win_valid;
    logic          win_last;

    logic [DATA_WIDTH-1:0]                  win_reg [KERNEL_DIM][KERNEL_DIM-1];
    logic [DATA_WIDTH-1:0]                  new_col [KERNEL_DIM];
    logic [(KERNEL_DIM-1)*DATA_WIDTH-1:0]   lb_rd;

    assign stall     = out_valid & ~out_ready;
    assign pix_ready = (state == RUN) & ~stall;
    assign in_fire   = pix_valid & pix_ready;
    assign out_fire  = out_valid & out_ready;
    assign k_fire    = k_valid & k_ready;
    assign conv_en   = in_fire | out_fire | ((state == FLUSH) & ~stall);
    assign last_pix  = (row == RW'(IMG_HEIGHT - 1)) & (col == CW'(IMG_WIDTH - 1));
    assign win_valid = in_fire & (row >= RW'(KERNEL_DIM - 1)) & (col >= CW'(KERNEL_DIM - 1));
    assign win_last  = win_valid & last_pix;
    assign out_valid = vld[1];
    assign out_last  = lst[1];
    assign out_data  = conv_feature;

    conv_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .KERNEL_DIM(KERNEL_DIM),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_line_buffer (
        .clk    (clk),
        .we     (in_fire),
        .col    (col),
        .din    (pix_data),
        .rd_data(lb_rd)
    );

    // The newest column comes straight from the line buffers and the live pixel, so the window is
    // complete in the same cycle the pixel is accepted; buffer row 0 is the most recent image row.
    for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_row
        if (r == KERNEL_DIM - 1) begin : g_pix
            assign new_col[r] = pix_data;
        end else begin : g_buf
            assign new_col[r] = lb_rd[(KERNEL_DIM-2-r)*DATA_WIDTH +: DATA_WIDTH];
        end
        for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_col
            if (c == KERNEL_DIM - 1) begin : g_new
                assign conv_image[(r*KERNEL_DIM+c)*DATA_WIDTH +: DATA_WIDTH] = new_col[r];
            end else begin : g_old
                assign conv_image[(r*KERNEL_DIM+c)*DATA_WIDTH +: DATA_WIDTH] = win_reg[r][c];
            end
        end
    end

    // frame sequencing with registered busy/done/k_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            k_ready <= 1'b0;
            k_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        k_ready <= 1'b1;
                        k_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (k_fire) begin
                        k_idx <= k_idx + 1'b1;
                        if (k_idx == KW'(KERNEL_SIZE - 1)) begin
                            state   <= RUN;
                            k_ready <= 1'b0;
                            k_idx   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (in_fire & last_pix) state <= FLUSH;
                end
                FLUSH: begin
                    if (vld == 2'b00) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    k_ready <= 1'b0;
                end
            endcase
        end
    end

    // kernel words land row-major in the slot given by the load index
    always_ff @(posedge clk) begin
        if (rst) conv_kernel <= '0;
        else if (k_fire) conv_kernel[k_idx*KDATA_WIDTH +: KDATA_WIDTH] <= k_data;
    end

    // stored window columns slide left by one on every accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_DIM; i++)
                for (int j = 0; j < KERNEL_DIM - 1; j++) win_reg[i][j] <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                for (int j = 0; j < KERNEL_DIM - 2; j++) win_reg[i][j] <= win_reg[i][j+1];
                win_reg[i][KERNEL_DIM-2] <= new_col[i];
            end
        end
    end

    // raster position counters; they wrap to zero after the final pixel, ready for the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_fire) begin
            col <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + 1'b1;
            if (col == CW'(IMG_WIDTH - 1)) row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
        end
    end

    // valid/last shadow of the 2-stage datapath; a shift without a pixel inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 2'b00;
            lst <= 2'b00;
        end else if (conv_en) begin
            vld <= {vld[0], win_valid};
            lst <= {lst[0], win_last};
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    // saturating count of back-pressured cycles, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if ((state == IDLE) & start) stall_cnt <= '0;
        else if (stall & (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: scoreboard bench for conv_ctrl on a 5x5 frame with a 2-stage multiply-accumulate datapath stub
module tb_conv_ctrl;
    import conv_pkg::*;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, k_valid, k_ready, pix_valid, pix_ready;
    logic        conv_en, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic [7:0]  k_data, pix_data, conv_feature, out_data, held;
    logic [71:0] conv_image, conv_kernel;
`ifdef CONV_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    logic [7:0]  dp0, dp1;
    logic [7:0]  img [NPIX];
    logic [7:0]  kern [9];
    exp_t        exp_q [$];
    int          n_vec = 0, n_err = 0, n_out = 0, n_done = 0, rdy_mode = 0;
    int          out_base = 0, done_base = 0;

    always #5 clk = ~clk;

    conv_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
`ifdef CONV_CTRL_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .k_valid     (k_valid),
        .k_ready     (k_ready),
        .k_data      (k_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .conv_en     (conv_en),
        .conv_image  (conv_image),
        .conv_kernel (conv_kernel),
        .conv_feature(conv_feature),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    function automatic logic [7:0] dp_f(input logic [71:0] im, input logic [71:0] kn);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 9; i++) s = s + im[i*8 +: 8] * kn[i*8 +: 8];
        return s;
    endfunction

    function automatic logic [7:0] ref_feat(input int r0, input int c0);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) s = s + img[(r0+i)*W + c0 + j] * kern[i*3 + j];
        return s;
    endfunction

    // two-stage datapath stand-in, advancing only on conv_en
    always @(posedge clk) begin
        if (rst) begin
            dp0 <= 8'h00;
            dp1 <= 8'h00;
        end else if (conv_en) begin
            dp0 <= dp_f(conv_image, conv_kernel);
            dp1 <= dp0;
        end
    end
    assign conv_feature = dp1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_start();
        out_base  = n_out;
        done_base = n_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_kready", k_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic load_kernel(input bit probe);
        int t;
        logic [71:0] kflat;
        if (probe) begin
            pix_valid = 1'b1;
            pix_data  = 8'hAA;
        end
        for (int i = 0; i < 9; i++) begin
            if (probe && (i % 3 == 1)) begin
                k_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
            k_valid = 1'b1;
            k_data  = kern[i];
            t = 0;
            @(negedge clk);
            while (!k_ready && t < 100) begin @(negedge clk); t++; end
            if (!k_ready) check("k_timeout", 0, 1);
            if (probe && i == 8) check("pix_ignored_in_load", pix_ready, 0);
            @(posedge clk); #1;
        end
        k_valid   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        for (int i = 0; i < 9; i++) kflat[i*8 +: 8] = kern[i];
        @(negedge clk);
        check("kernel0", conv_kernel[7:0], kern[0]);
        check("kernel8", conv_kernel[71:64], kern[8]);
        check("kernel_all", conv_kernel, kflat);
        check("run_ready", pix_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_pix(input int p, input bit gaps, input bit win_chk);
        int t;
        int r = p / W;
        int c = p % W;
        conv_win_t w;
        logic [71:0] wflat;
        exp_t e;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        pix_valid = 1'b1;
        pix_data  = img[p];
        t = 0;
        @(negedge clk);
        while (!pix_ready && t < 200) begin @(negedge clk); t++; end
        if (!pix_ready) check("pix_timeout", 0, 1);
        if (win_chk && r == 2 && c == 2) begin
            for (int i = 0; i < 9; i++) w[i] = img[(i/3)*W + (i%3)];
            for (int i = 0; i < 9; i++) wflat[i*8 +: 8] = w[i];
            check("first_window", conv_image, wflat);
            check("first_window_en", conv_en, 1);
        end
        if (r >= 2 && c >= 2) begin
            e.last = (r == H-1) && (c == W-1);
            e.data = ref_feat(r - 2, c - 2);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done && t < 500) begin @(negedge clk); t++; end
        check("done_seen", done, 1);
        check("beats", n_out - out_base, NOUT);
        check("q_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("done_count", n_done - done_base, 1);
        @(posedge clk); #1;
    endtask

    task automatic randomize_frame();
        for (int p = 0; p < NPIX; p++) img[p] = 8'($urandom);
        for (int i = 0; i < 9; i++) kern[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_valid = 1'b0; k_data = 8'h00; pix_valid = 1'b0; pix_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kready", k_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_conv_en", conv_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_kernel", conv_kernel, 0);
        check("rst_image", conv_image, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ramp frame, gapped kernel load, stray start mid-frame
        for (int p = 0; p < NPIX; p++) img[p] = 8'(p);
        for (int i = 0; i < 9; i++) kern[i] = 8'(i + 1);
        do_start();
        load_kernel(1'b1);
        for (int p = 0; p < NPIX; p++) begin
            if (p == 6) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_pix(p, 1'b0, 1'b1);
        end
        wait_done();

        // back-pressure: first result held for five cycles
        rdy_mode = 2;
        randomize_frame();
        do_start();
        load_kernel(1'b0);
        for (int p = 0; p < 14; p++) send_pix(p, 1'b0, 1'b0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_pix_ready", pix_ready, 0);
            check("stall_conv_en", conv_en, 0);
            check("stall_hold", out_data, held);
        end
        rdy_mode = 0;
`ifdef CONV_CTRL_STALL_CNT_EN
        @(negedge clk);
        check("stall_cnt", stall_cnt, 5);
`endif
        @(posedge clk); #1;
        for (int p = 14; p < NPIX; p++) send_pix(p, 1'b0, 1'b0);
        wait_done();

        // abort mid-frame with reset
        randomize_frame();
        do_start();
        load_kernel(1'b0);
        for (int p = 0; p < 13; p++) send_pix(p, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pix_ready", pix_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_conv_en", conv_en, 0);
        check("abort_kernel", conv_kernel, 0);
        out_base  = n_out;
        done_base = n_done;
        repeat (10) @(negedge clk);
        check("abort_no_done", n_done - done_base, 0);
        check("abort_no_beats", n_out - out_base, 0);
        @(posedge clk); #1;

        // random pixel gaps and random out_ready
        rdy_mode = 1;
        randomize_frame();
        do_start();
        load_kernel(1'b1);
        for (int p = 0; p < NPIX; p++) send_pix(p, 1'b1, 1'b0);
        wait_done();
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
